// File: rtl/uart_cmd_counter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_cmd_counter_if : RX byte strobe and TX FIFO push bus of the counter.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface uart_cmd_counter_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_full;
  logic [7:0] tx_data;
  logic       tx_push;

  modport master (
    output rx_data,
    output rx_done,
    output tx_full,
    input  tx_data,
    input  tx_push
  );

  modport slave (
    input  rx_data,
    input  rx_done,
    input  tx_full,
    output tx_data,
    output tx_push
  );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_cmd_counter : button/UART driven BCD up/down counter with ASCII       |
// |                    report through the TX FIFO push interface.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_cmd_counter #(
  parameter int TICK_DIV = 10_000_000,
  parameter int DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_btn_run,
  input  logic                  i_btn_clear,
  input  logic                  i_btn_mode,
  uart_cmd_counter_if.slave     bus,
  output logic [4*DIGITS-1:0]   o_count_bcd,
  output logic                  o_running,
  output logic                  o_down_mode,
  output logic                  o_busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] c_PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [IW-1:0] c_IDX_TOP    = IW'(DIGITS - 1);
  localparam logic [7:0]    c_CHR_CR     = 8'h0D;
  localparam logic [7:0]    c_CHR_LF     = 8'h0A;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIG  = 2'd1,
    S_CR   = 2'd2,
    S_LF   = 2'd3
  } state_t;

  logic [4*DIGITS-1:0] r_count;
  logic [PW-1:0]       r_presc;
  logic                r_running;
  logic                r_down;
  state_t              r_state;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_shadow;

  logic [7:0]          w_lc;
  logic                w_cmd_run;
  logic                w_cmd_clear;
  logic                w_cmd_mode;
  logic                w_cmd_report;
  logic                w_step;
  logic [4*DIGITS-1:0] w_count_step;
  logic [3:0]          w_digit;
  logic                w_chain;
  logic [3:0]          w_shadow_dig;
  state_t              w_state_nxt;
  logic [IW-1:0]       w_idx_nxt;
  logic [4*DIGITS-1:0] w_shadow_nxt;
  logic [7:0]          w_tx_data;
  logic                w_tx_push;

  // Upper and lower case letters differ only in bit 5.
  assign w_lc         = bus.rx_data | 8'h20;
  assign w_cmd_run    = i_btn_run   | (bus.rx_done & (w_lc == 8'h72));
  assign w_cmd_clear  = i_btn_clear | (bus.rx_done & (w_lc == 8'h63));
  assign w_cmd_mode   = i_btn_mode  | (bus.rx_done & (w_lc == 8'h6D));
  assign w_cmd_report = bus.rx_done & (w_lc == 8'h73);

  assign w_step = r_running & (r_presc == c_PRESC_LAST);

  // Ripple the carry/borrow from digit 0 upward; a digit that absorbs it stops the chain.
  always_comb begin
    w_count_step = r_count;
    w_chain      = 1'b1;
    w_digit      = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      w_digit = r_count[4*i +: 4];
      if (w_chain) begin
        if (r_down) begin
          if (w_digit == 4'd0) begin
            w_digit = 4'd9;
          end else begin
            w_digit = w_digit - 4'd1;
            w_chain = 1'b0;
          end
        end else begin
          if (w_digit >= 4'd9) begin
            w_digit = 4'd0;
          end else begin
            w_digit = w_digit + 4'd1;
            w_chain = 1'b0;
          end
        end
      end
      w_count_step[4*i +: 4] = w_digit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_presc   <= '0;
      r_running <= 1'b0;
      r_down    <= 1'b0;
    end else begin
      r_running <= r_running ^ w_cmd_run;
      r_down    <= r_down ^ w_cmd_mode;
      if (w_cmd_clear) begin
        r_count <= '0;
        r_presc <= '0;
      end else if (r_running) begin
        if (w_step) begin
          r_presc <= '0;
          r_count <= w_count_step;
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
    end
  end

  assign w_shadow_dig = r_shadow[4*int'(r_idx) +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_shadow <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_shadow <= w_shadow_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_shadow_nxt = r_shadow;
    w_tx_data    = 8'h00;
    w_tx_push    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_report) begin
          w_shadow_nxt = r_count;
          w_idx_nxt    = c_IDX_TOP;
          w_state_nxt  = S_DIG;
        end
      end
      S_DIG: begin
        w_tx_data = {4'h3, w_shadow_dig};
        if (!bus.tx_full) begin
          w_tx_push = 1'b1;
          if (r_idx == '0) begin
            w_state_nxt = S_CR;
          end else begin
            w_idx_nxt = r_idx - IW'(1);
          end
        end
      end
      S_CR: begin
        w_tx_data = c_CHR_CR;
        if (!bus.tx_full) begin
          w_tx_push   = 1'b1;
          w_state_nxt = S_LF;
        end
      end
      S_LF: begin
        w_tx_data = c_CHR_LF;
        if (!bus.tx_full) begin
          w_tx_push   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.tx_data  = w_tx_data;
  assign bus.tx_push  = w_tx_push;
  assign o_count_bcd  = r_count;
  assign o_running    = r_running;
  assign o_down_mode  = r_down;
  assign o_busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
